// File: rtl/xor_parity_rx.sv
// Serial receiver for start/data/even-parity/stop frames on an idle-high line.
// It delivers the data word with a one-cycle valid strobe plus parity and framing error pulses.
module xor_parity_rx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              busy_o
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
    } state_t;

    state_t            state_q, state_d;
    logic              rx_meta_q, rx_s_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              acc_q, acc_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              wrap;

    // Synchronizer resets high so that leaving reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            acc_q   <= 1'b0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign wrap = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        pend_d  = pend_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                    idx_d   = '0;
                    acc_d   = 1'b0;
                end
            end
            START: begin
                // Mid-start-bit check rejects short low glitches.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (wrap) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
                    acc_d   = acc_q ^ rx_s_q;
                    if (idx_q == IDX_LAST) state_d = PARITY;
                    else                   idx_d   = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (wrap) begin
                    cnt_d   = '0;
                    pend_d  = rx_s_q ^ acc_q;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (wrap) begin
                    cnt_d   = '0;
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    perr_d  = pend_q;
                    ferr_d  = ~rx_s_q;
                    state_d = rx_s_q ? IDLE : WAIT_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                // A held-low break line must return high before a new frame is accepted.
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_xor_parity_rx.sv
// Directed bench for xor_parity_rx: clean, parity error, break, glitch, mid-frame reset and back-to-back frames.
module tb_xor_parity_rx;

    localparam int N       = 4;
    localparam int H       = 2;
    localparam int DW      = 8;
    localparam int T_VALID = 45;   // rx_i fall -> valid seen: 1 + 2 sync + H + (DW+2)*N

    logic          clk;
    logic          rst;
    logic          rx_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          parity_err_o;
    logic          frame_err_o;
    logic          busy_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int base;

    int            valid_cnt  = 0;
    int            v_cyc      = 0;
    int            v_cyc_prev = 0;
    logic [DW-1:0] v_data      = '0;
    logic [DW-1:0] v_data_prev = '0;
    logic          v_perr      = 1'b0;
    logic          v_ferr      = 1'b0;

    xor_parity_rx #(.CLKS_PER_BIT(N), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_o) begin
            valid_cnt   = valid_cnt + 1;
            v_cyc_prev  = v_cyc;
            v_data_prev = v_data;
            v_cyc       = cyc;
            v_data      = data_o;
            v_perr      = parity_err_o;
            v_ferr      = frame_err_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge ending the stop bit, line left at the stop value.
    task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s);
        rx_i     = 1'b0;
        fall_cyc = cyc;
        repeat (N) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            rx_i = d[i];
            repeat (N) @(negedge clk);
        end
        rx_i = p;
        repeat (N) @(negedge clk);
        rx_i = s;
        repeat (N) @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        rx_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(data_o), 32'h0);
        chk("rst_flags", {28'h0, valid_o, parity_err_o, frame_err_o, busy_o}, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_flags", {28'h0, valid_o, parity_err_o, frame_err_o, busy_o}, 32'h0);

        // clean 0xA5
        base = valid_cnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("a5_count", 32'(valid_cnt), 32'(base + 1));
        chk("a5_timing", 32'(v_cyc), 32'(fall_cyc + T_VALID));
        chk("a5_data", 32'(v_data), 32'hA5);
        chk("a5_perr", 32'(v_perr), 32'h0);
        chk("a5_ferr", 32'(v_ferr), 32'h0);
        chk("a5_busy", 32'(busy_o), 32'h0);
        chk("a5_hold", 32'(data_o), 32'hA5);

        // 0x01 with wrong parity
        base = valid_cnt;
        send_frame(8'h01, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("perr_count", 32'(valid_cnt), 32'(base + 1));
        chk("perr_data", 32'(v_data), 32'h01);
        chk("perr_perr", 32'(v_perr), 32'h1);
        chk("perr_ferr", 32'(v_ferr), 32'h0);

        // 0x3C with stop 0, then a long break
        base = valid_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("brk_count", 32'(valid_cnt), 32'(base + 1));
        chk("brk_data", 32'(v_data), 32'h3C);
        chk("brk_ferr", 32'(v_ferr), 32'h1);
        chk("brk_perr", 32'(v_perr), 32'h0);
        chk("brk_busy", 32'(busy_o), 32'h1);
        repeat (20 * N) @(negedge clk);
        chk("brk_hold_count", 32'(valid_cnt), 32'(base + 1));
        chk("brk_hold_busy", 32'(busy_o), 32'h1);
        rx_i = 1'b1;
        repeat (2 * N) @(negedge clk);
        chk("brk_release_busy", 32'(busy_o), 32'h0);
        base = valid_cnt;
        send_frame(8'hFF, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("rec_count", 32'(valid_cnt), 32'(base + 1));
        chk("rec_data", 32'(v_data), 32'hFF);
        chk("rec_flags", {30'h0, v_perr, v_ferr}, 32'h0);

        // one-cycle start glitch
        base = valid_cnt;
        rx_i = 1'b0;
        @(negedge clk);
        rx_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy_seen", 32'(busy_o), 32'h1);
        repeat (H + 3) @(negedge clk);
        chk("glitch_busy_clear", 32'(busy_o), 32'h0);
        repeat (60) @(negedge clk);
        chk("glitch_count", 32'(valid_cnt), 32'(base));
        chk("glitch_data_hold", 32'(data_o), 32'hFF);

        // reset during data bit 4 of 0x5A
        rx_i = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_i = (8'h5A >> i) & 8'h01;
            repeat (N) @(negedge clk);
        end
        rx_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_busy_before", 32'(busy_o), 32'h1);
        base = valid_cnt;
        rst = 1'b1;
        #1;
        chk("mid_rst_data", 32'(data_o), 32'h0);
        chk("mid_rst_flags", {28'h0, valid_o, parity_err_o, frame_err_o, busy_o}, 32'h0);
        @(negedge clk);
        rst  = 1'b0;
        rx_i = 1'b1;
        repeat (2 * N) @(negedge clk);
        chk("mid_no_pulse", 32'(valid_cnt), 32'(base));
        send_frame(8'h5A, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("mid_count", 32'(valid_cnt), 32'(base + 1));
        chk("mid_data", 32'(v_data), 32'h5A);
        chk("mid_flags", {30'h0, v_perr, v_ferr}, 32'h0);

        // back-to-back 0x00 then 0xFF
        base = valid_cnt;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("b2b_count", 32'(valid_cnt), 32'(base + 2));
        chk("b2b_spacing", 32'(v_cyc - v_cyc_prev), 32'((DW + 3) * N));
        chk("b2b_first_data", 32'(v_data_prev), 32'h00);
        chk("b2b_second_data", 32'(v_data), 32'hFF);
        chk("b2b_flags", {30'h0, v_perr, v_ferr}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
